// File: rtl/l1d_dn_pkg.sv
// l1d_dn_pkg: shared types and constants for the L1D downstream responder.
// Widths here define the entry and evict payload layouts.
package l1d_dn_pkg;

    localparam int DN_ADDR_W    = 32;
    localparam int DN_LINE_W    = 256;
    localparam int DN_ID_W      = 4;
    localparam int DN_MEM_LINES = 64;
    localparam int DN_LATENCY   = 4;
    localparam int DN_QDEPTH    = 4;

    localparam int OFF   = $clog2(DN_LINE_W / 8);
    localparam int IDX   = $clog2(DN_MEM_LINES);
    localparam int AGE_W = $clog2(DN_LATENCY + 1);

    typedef struct packed {
        logic [DN_ID_W-1:0] id;
        logic [IDX-1:0]     index;
        logic [AGE_W-1:0]   age;
    } dn_q_entry_t;

    typedef struct packed {
        logic [DN_ADDR_W-1:0] addr;
        logic [DN_LINE_W-1:0] data;
    } dn_evict_pld_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dn_state_e;

    // Power-on line pattern: every 32-bit word carries the line number.
    function automatic logic [DN_LINE_W-1:0] init_line(input logic [IDX-1:0] i);
        return {(DN_LINE_W / 32){32'(i)}};
    endfunction

endpackage

// File: rtl/l1d_dn_req_fifo.sv
// l1d_dn_req_fifo: in-order queue of outstanding refills with per-entry
// age counters; flags the head once it has aged enough to be answered.
module l1d_dn_req_fifo
    import l1d_dn_pkg::*;
#(
    parameter int DEPTH = DN_QDEPTH,
    parameter int LAT   = DN_LATENCY,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [DN_ID_W-1:0]  push_id_i,
    input  logic [IDX-1:0]      push_idx_i,
    input  logic                pop_i,
    input  logic                out_free_i,
    output dn_q_entry_t         head_o,
    output logic                head_elig_o,
    output logic [CW-1:0]       count_o
);

    dn_q_entry_t   q_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    // Entry storage: ages saturate at LAT, a push overwrites its slot fresh.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_q[i].age < AGE_W'(LAT)) begin
                q_q[i].age <= q_q[i].age + AGE_W'(1);
            end
        end
        if (push_i) begin
            q_q[wr_q] <= '{id: push_id_i, index: push_idx_i, age: '0};
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o      = q_q[rd_q];
    assign head_elig_o = (cnt_q != '0)
                       && (head_o.age >= AGE_W'(LAT - 1))
                       && out_free_i;
    assign count_o     = cnt_q;

endmodule

// File: rtl/l1d_downstream_responder.sv
// l1d_downstream_responder: L2/memory stand-in for the L1D downstream port.
// Returns refill data in order after a fixed latency, absorbs evictions.
module l1d_downstream_responder
    import l1d_dn_pkg::*;
#(
    parameter int ADDR_W    = DN_ADDR_W,
    parameter int LINE_W    = DN_LINE_W,
    parameter int ID_W      = DN_ID_W,
    parameter int MEM_LINES = DN_MEM_LINES,
    parameter int LATENCY   = DN_LATENCY,
    parameter int QDEPTH    = DN_QDEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     downstream_req_vld,
    output logic                     downstream_req_rdy,
    input  logic [ADDR_W-1:0]        downstream_req_pld,
    input  logic [ID_W-1:0]          downstream_req_id,
    output logic                     downstream_rsp_vld,
    input  logic                     downstream_rsp_rdy,
    output logic [LINE_W-1:0]        downstream_rsp_pld,
    output logic [ID_W-1:0]          downstream_rsp_id,
    input  logic                     downstream_evict_vld,
    input  logic [ADDR_W+LINE_W-1:0] downstream_evict_pld,
    output logic                     downstream_evict_rdy
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    dn_state_e         state_q;
    logic [IDX-1:0]    init_cnt_q;
    logic [LINE_W-1:0] mem_q [MEM_LINES];

    logic              rsp_vld_q;
    logic [LINE_W-1:0] rsp_pld_q;
    logic [LINE_W-1:0] rsp_pld_d;
    logic [ID_W-1:0]   rsp_id_q;

    dn_evict_pld_t     ev;
    logic [IDX-1:0]    req_idx;
    logic [IDX-1:0]    ev_idx;
    logic              run;
    logic              req_fire;
    logic              ev_fire;
    logic              pop;
    logic              out_free;
    dn_q_entry_t       head;
    logic [CNT_W-1:0]  q_count;
    logic              unused_bits;

    assign ev      = downstream_evict_pld;
    assign req_idx = downstream_req_pld[OFF+IDX-1:OFF];
    assign ev_idx  = ev.addr[OFF+IDX-1:OFF];
    assign run     = (state_q == RUN);

    // Ready depends only on state and occupancy, never on input valids.
    assign downstream_req_rdy   = run && (q_count < CNT_W'(QDEPTH));
    assign downstream_evict_rdy = run;

    assign req_fire = downstream_req_vld && downstream_req_rdy;
    assign ev_fire  = downstream_evict_vld && downstream_evict_rdy;
    assign out_free = !rsp_vld_q || downstream_rsp_rdy;

    l1d_dn_req_fifo #(
        .DEPTH (QDEPTH),
        .LAT   (LATENCY)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_fire),
        .push_id_i   (downstream_req_id),
        .push_idx_i  (req_idx),
        .pop_i       (pop),
        .out_free_i  (out_free),
        .head_o      (head),
        .head_elig_o (pop),
        .count_o     (q_count)
    );

    // INIT walks every line once, then the responder runs until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + IDX'(1);
                    if (init_cnt_q == IDX'(MEM_LINES - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    // Backing store: init pattern during INIT, evictions while running.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT) begin
                mem_q[init_cnt_q] <= init_line(init_cnt_q);
            end else if (ev_fire) begin
                mem_q[ev_idx] <= ev.data;
            end
        end
    end

    // A same-cycle eviction to the popped line wins over stored data.
    always_comb begin
        rsp_pld_d = mem_q[head.index];
        if (ev_fire && (ev_idx == head.index)) begin
            rsp_pld_d = ev.data;
        end
    end

    // Response register: load on pop, hold while stalled, drop when taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_pld_q <= '0;
            rsp_id_q  <= '0;
        end else if (pop) begin
            rsp_vld_q <= 1'b1;
            rsp_pld_q <= rsp_pld_d;
            rsp_id_q  <= head.id;
        end else if (downstream_rsp_rdy) begin
            rsp_vld_q <= 1'b0;
        end
    end

    assign downstream_rsp_vld = rsp_vld_q;
    assign downstream_rsp_pld = rsp_pld_q;
    assign downstream_rsp_id  = rsp_id_q;

    // Address bits outside the line index alias onto the same line.
    assign unused_bits = ^{downstream_req_pld[ADDR_W-1:OFF+IDX],
                           downstream_req_pld[OFF-1:0],
                           ev.addr[ADDR_W-1:OFF+IDX],
                           ev.addr[OFF-1:0],
                           head.age};

endmodule
